// File: rtl/demux_1to3_stream.sv
// Routes one valid/ready stream to one of three single-entry output channels,
// selected per beat; illegal-select beats are dropped and counted.
module demux_1to3_stream #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic [2:0]       out_valid,
    input  logic [2:0]       out_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic [WIDTH-1:0] out1_data,
    output logic [WIDTH-1:0] out2_data,
    output logic             err_sel,
    output logic [CNT_W-1:0] drop_count
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ch_state_t;

    logic [2:0]       full;
    logic [3:0]       full_ext;
    logic [3:0]       out_ready_ext;
    logic             accept;
    logic             illegal;
    logic [WIDTH-1:0] data_arr [3];
    logic             err_sel_reg;
    logic [CNT_W-1:0] drop_count_reg;

    // Select 3 maps to the padding bit so illegal beats are always taken.
    assign full_ext      = {1'b0, full};
    assign out_ready_ext = {1'b0, out_ready};
    assign in_ready      = !rst && (in_sel == 2'd3 || !full_ext[in_sel] || out_ready_ext[in_sel]);
    assign accept        = in_valid && in_ready;
    assign illegal       = accept && (in_sel == 2'd3);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ch
            ch_state_t        state_reg, state_next;
            logic [WIDTH-1:0] data_reg;
            logic             load;

            assign load = accept && (in_sel == 2'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_reg <= EMPTY;
                end else begin
                    state_reg <= state_next;
                end
            end

            // A load wins over a drain so a ready consumer sees one beat per cycle.
            always_comb begin
                state_next = state_reg;
                if (load) begin
                    state_next = FULL;
                end else if (out_ready[gi] && state_reg == FULL) begin
                    state_next = EMPTY;
                end
            end

            always_comb begin
                full[gi] = (state_reg == FULL);
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_reg <= '0;
                end else if (load) begin
                    data_reg <= in_data;
                end
            end

            assign data_arr[gi] = data_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sel_reg    <= 1'b0;
            drop_count_reg <= '0;
        end else begin
            err_sel_reg <= illegal;
            if (illegal && drop_count_reg != {CNT_W{1'b1}}) begin
                drop_count_reg <= drop_count_reg + 1'b1;
            end
        end
    end

    assign out_valid  = full;
    assign out0_data  = data_arr[0];
    assign out1_data  = data_arr[1];
    assign out2_data  = data_arr[2];
    assign err_sel    = err_sel_reg;
    assign drop_count = drop_count_reg;

endmodule
